// File: rtl/game_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : game_scheduler
// Description : Sequences one game round. Steps the sprite x offset from
//               X_START down to 0 at a programmable rate, shortens the step
//               period after every pass (clamped at DELAY_MIN), credits at
//               most one hit per pass, removes a life for each pass without
//               a hit and ends the game when the last life is gone.
// Ports       : clk       - system clock (CLOCK_50)
//               reset_b   - asynchronous active-low reset
//               start     - start/restart request, rising edge only
//               pause     - level, freezes play while high
//               hit       - one-cycle hit pulse from hit_detector
//               xoffset   - sprite x to Graphics
//               yoffset   - sprite y, constant Y_POS
//               score     - hits credited, saturating at 255
//               lives     - remaining lives
//               level     - completed passes, saturating at 15
//               step      - one-cycle pulse with every xoffset change
//               playing   - high while in PLAY
//               game_over - high while in OVER
// Revision    : 1.0 - initial release
// ============================================================================
module game_scheduler #(
  parameter int X_START    = 160,
  parameter int Y_POS      = 120,
  parameter int DELAY_INIT = 5000000,
  parameter int DELAY_STEP = 500000,
  parameter int DELAY_MIN  = 1000000,
  parameter int LIVES_INIT = 3
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  output logic [8:0] xoffset,
  output logic [7:0] yoffset,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic       step,
  output logic       playing,
  output logic       game_over
);

  localparam logic [8:0]  c_x_start    = 9'(X_START);
  localparam logic [7:0]  c_y_pos      = 8'(Y_POS);
  localparam logic [23:0] c_delay_init = 24'(DELAY_INIT);
  localparam logic [23:0] c_delay_step = 24'(DELAY_STEP);
  localparam logic [23:0] c_delay_min  = 24'(DELAY_MIN);
  localparam logic [1:0]  c_lives_init = 2'(LIVES_INIT);
  // Threshold below which the next reload clamps to the floor; one extra
  // bit so the sum itself cannot wrap.
  localparam logic [24:0] c_floor_sum  = 25'(DELAY_MIN) + 25'(DELAY_STEP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t      r_state;
  logic [8:0]  r_xoffset;
  logic [7:0]  r_score;
  logic [1:0]  r_lives;
  logic [3:0]  r_level;
  logic        r_step;
  logic        r_playing;
  logic        r_game_over;
  logic [23:0] r_delay_cnt;
  logic [23:0] r_cur_delay;
  logic        r_pass_hit;
  logic        r_start_q;

  logic        w_start_rise;
  logic        w_cnt_zero;
  logic        w_pass_end;
  logic        w_credit;
  logic        w_miss;
  logic [23:0] w_next_delay;
  logic [7:0]  w_score_inc;
  logic [3:0]  w_level_inc;

  assign w_start_rise = start & ~r_start_q;
  assign w_cnt_zero   = (r_delay_cnt == 24'd0);
  assign w_pass_end   = w_cnt_zero && (r_xoffset == 9'd0);
  // Only the first hit of a pass is credited.
  assign w_credit     = hit & ~r_pass_hit;
  // A hit arriving on the pass-end cycle still counts for the ending pass.
  assign w_miss       = ~r_pass_hit & ~hit;
  assign w_next_delay = ({1'b0, r_cur_delay} < c_floor_sum) ? c_delay_min
                                                            : (r_cur_delay - c_delay_step);
  assign w_score_inc  = (r_score == 8'hFF) ? r_score : (r_score + 8'd1);
  assign w_level_inc  = (r_level == 4'hF)  ? r_level : (r_level + 4'd1);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state     <= ST_IDLE;
      r_xoffset   <= c_x_start;
      r_score     <= 8'd0;
      r_lives     <= c_lives_init;
      r_level     <= 4'd0;
      r_step      <= 1'b0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
      r_delay_cnt <= c_delay_init;
      r_cur_delay <= c_delay_init;
      r_pass_hit  <= 1'b0;
      r_start_q   <= 1'b0;
    end else begin
      r_start_q <= start;
      r_step    <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (w_start_rise) begin
            r_state     <= ST_PLAY;
            r_xoffset   <= c_x_start;
            r_score     <= 8'd0;
            r_lives     <= c_lives_init;
            r_level     <= 4'd0;
            r_playing   <= 1'b1;
            r_game_over <= 1'b0;
            r_delay_cnt <= c_delay_init;
            r_cur_delay <= c_delay_init;
            r_pass_hit  <= 1'b0;
          end
        end

        ST_PLAY: begin
          // Pause takes effect on the cycle it is seen: nothing advances.
          if (pause) begin
            r_state <= ST_PAUSE;
          end else begin
            if (w_credit) begin
              r_score <= w_score_inc;
            end
            if (w_pass_end) begin
              r_pass_hit <= 1'b0;
            end else if (w_credit) begin
              r_pass_hit <= 1'b1;
            end

            if (!w_cnt_zero) begin
              r_delay_cnt <= r_delay_cnt - 24'd1;
            end else begin
              r_step <= 1'b1;
              if (!w_pass_end) begin
                r_xoffset   <= r_xoffset - 9'd1;
                r_delay_cnt <= r_cur_delay;
              end else begin
                // The new, shorter period applies from the very next step.
                r_xoffset   <= c_x_start;
                r_level     <= w_level_inc;
                r_cur_delay <= w_next_delay;
                r_delay_cnt <= w_next_delay;
                if (w_miss) begin
                  r_lives <= r_lives - 2'd1;
                  if (r_lives == 2'd1) begin
                    r_state     <= ST_OVER;
                    r_playing   <= 1'b0;
                    r_game_over <= 1'b1;
                  end
                end
              end
            end
          end
        end

        ST_PAUSE: begin
          if (!pause) begin
            r_state <= ST_PLAY;
          end
        end
      endcase
    end
  end

  assign xoffset   = r_xoffset;
  assign yoffset   = c_y_pos;
  assign score     = r_score;
  assign lives     = r_lives;
  assign level     = r_level;
  assign step      = r_step;
  assign playing   = r_playing;
  assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_game_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_scheduler
// Description : Self-checking bench for game_scheduler with small timing
//               parameters (X_START=2, DELAY_INIT=4, DELAY_STEP=2,
//               DELAY_MIN=1, LIVES_INIT=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_scheduler;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       start;
  logic       pause;
  logic       hit;
  logic [8:0] xoffset;
  logic [7:0] yoffset;
  logic [7:0] score;
  logic [1:0] lives;
  logic [3:0] level;
  logic       step;
  logic       playing;
  logic       game_over;

  always #5 clk = ~clk;

  game_scheduler #(
    .X_START    (2),
    .Y_POS      (120),
    .DELAY_INIT (4),
    .DELAY_STEP (2),
    .DELAY_MIN  (1),
    .LIVES_INIT (3)
  ) u_dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .start     (start),
    .pause     (pause),
    .hit       (hit),
    .xoffset   (xoffset),
    .yoffset   (yoffset),
    .score     (score),
    .lives     (lives),
    .level     (level),
    .step      (step),
    .playing   (playing),
    .game_over (game_over)
  );

  typedef struct {
    int         cycles;
    logic       start;
    logic       pause;
    logic       hit;
    logic [8:0] x;
    logic [7:0] score;
    logic [1:0] lives;
    logic [3:0] level;
    logic       chk_level;
    logic       step;
    logic       playing;
    logic       over;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   per_q[$];
  int   lives_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic vec_t mk(input int c, input logic s, input logic p, input logic h,
                              input int x, input int sc, input int lv, input int lvl,
                              input logic cl, input logic st, input logic pl, input logic ov);
    vec_t v;
    v.cycles = c;  v.start = s; v.pause = p; v.hit = h;
    v.x = 9'(x); v.score = 8'(sc); v.lives = 2'(lv); v.level = 4'(lvl);
    v.chk_level = cl; v.step = st; v.playing = pl; v.over = ov;
    return v;
  endfunction

  // Waits for the next step pulse; returns the number of edges taken, or -1
  // when the bound expires.
  task automatic wait_step(input int bound, output int n);
    n = 0;
    do begin
      cyc(1);
      hit = 1'b0;
      n++;
    end while (!step && n < bound);
    if (!step) n = -1;
  endtask

  initial begin
    int   n;
    int   nsteps;
    vec_t v;

    reset_b = 1'b0;
    start   = 1'b0;
    pause   = 1'b0;
    hit     = 1'b0;

    // cycles, start, pause, hit | x, score, lives, level, chk_level, step, playing, over
    vecs.push_back(mk( 1, 0, 0, 0, 2, 0, 3, 0, 1, 0, 0, 0)); // idle after reset
    vecs.push_back(mk( 1, 1, 0, 0, 2, 0, 3, 0, 1, 0, 1, 0)); // start
    vecs.push_back(mk( 4, 0, 0, 0, 2, 0, 3, 0, 1, 0, 1, 0)); // counting down
    vecs.push_back(mk( 1, 0, 0, 0, 1, 0, 3, 0, 1, 1, 1, 0)); // first step, period 5
    vecs.push_back(mk( 1, 0, 0, 0, 1, 0, 3, 0, 1, 0, 1, 0));
    vecs.push_back(mk( 4, 0, 0, 0, 0, 0, 3, 0, 1, 1, 1, 0)); // x reaches 0
    vecs.push_back(mk( 5, 0, 0, 0, 2, 0, 2, 1, 1, 1, 1, 0)); // unhit pass end
    vecs.push_back(mk( 3, 0, 0, 0, 1, 0, 2, 1, 1, 1, 1, 0)); // period now 3
    vecs.push_back(mk( 1, 0, 0, 1, 1, 1, 2, 1, 1, 0, 1, 0)); // first hit credited
    vecs.push_back(mk( 1, 0, 0, 0, 1, 1, 2, 1, 1, 0, 1, 0));
    vecs.push_back(mk( 1, 0, 0, 1, 0, 1, 2, 1, 1, 1, 1, 0)); // second hit ignored
    vecs.push_back(mk( 1, 0, 0, 0, 0, 1, 2, 1, 1, 0, 1, 0));
    vecs.push_back(mk( 1, 0, 0, 1, 0, 1, 2, 1, 1, 0, 1, 0)); // third hit ignored
    vecs.push_back(mk( 1, 0, 0, 0, 2, 1, 2, 2, 1, 1, 1, 0)); // hit pass: no life lost
    vecs.push_back(mk( 5, 0, 0, 0, 0, 1, 2, 2, 1, 0, 1, 0)); // period 2 now
    vecs.push_back(mk( 1, 0, 0, 1, 2, 2, 2, 3, 1, 1, 1, 0)); // hit on pass-end cycle
    vecs.push_back(mk( 6, 0, 0, 0, 2, 2, 1, 4, 1, 1, 1, 0)); // pass_hit had cleared
    vecs.push_back(mk( 6, 0, 0, 0, 2, 2, 0, 0, 0, 1, 0, 1)); // last life -> OVER
    vecs.push_back(mk( 1, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0, 1)); // hit in OVER ignored
    vecs.push_back(mk( 1, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(10, 1, 0, 0, 1, 0, 3, 0, 1, 0, 1, 0)); // start held: one restart
    vecs.push_back(mk( 1, 0, 0, 0, 0, 0, 3, 0, 1, 1, 1, 0));

    cyc(2);
    reset_b = 1'b1;
    chk("reset_yoffset", yoffset, 120);

    for (int i = 0; i < vecs.size(); i++) begin
      v     = vecs[i];
      start = v.start;
      pause = v.pause;
      hit   = v.hit;
      exp_q.push_back(v);
      cyc(v.cycles);
      v = exp_q.pop_front();
      chk($sformatf("v%0d_xoffset", i), xoffset, v.x);
      chk($sformatf("v%0d_score", i), score, v.score);
      chk($sformatf("v%0d_lives", i), lives, v.lives);
      if (v.chk_level) chk($sformatf("v%0d_level", i), level, v.level);
      chk($sformatf("v%0d_step", i), step, v.step);
      chk($sformatf("v%0d_playing", i), playing, v.playing);
      chk($sformatf("v%0d_game_over", i), game_over, v.over);
    end
    start = 1'b0;
    hit   = 1'b0;

    // Four passes, hit only in the first: periods 5,3,2,2 and lives 3,2,1,0.
    reset_b = 1'b0;
    cyc(2);
    reset_b = 1'b1;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    foreach (per_q[k]) per_q[k] = 0;
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < 3; s++) per_q.push_back(p == 0 ? 5 : (p == 1 ? 3 : 2));
      lives_q.push_back(3 - p);
    end
    nsteps = per_q.size();
    for (int i = 0; i < nsteps; i++) begin
      if (i == 0) hit = 1'b1;
      wait_step(20, n);
      chk($sformatf("period_%0d", i), n, per_q.pop_front());
      if (n < 0) break;
      if ((i % 3) == 2) chk($sformatf("pass_lives_%0d", i / 3), lives, lives_q.pop_front());
    end
    chk("over_game_over", game_over, 1);
    chk("over_playing", playing, 0);
    chk("over_score", score, 1);

    // Pause for 20 cycles with two counts left; resume finishes the count.
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    pause = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (step) n++;
    end
    chk("pause_steps", n, 0);
    chk("pause_xoffset", xoffset, 2);
    pause = 1'b0;
    wait_step(20, n);
    chk("resume_period", n, 4);
    chk("resume_xoffset", xoffset, 1);

    // Asynchronous reset mid-play, checked before any clock edge.
    cyc(2);
    #2;
    reset_b = 1'b0;
    #1;
    chk("areset_xoffset", xoffset, 2);
    chk("areset_yoffset", yoffset, 120);
    chk("areset_score", score, 0);
    chk("areset_lives", lives, 3);
    chk("areset_level", level, 0);
    chk("areset_step", step, 0);
    chk("areset_playing", playing, 0);
    chk("areset_game_over", game_over, 0);
    cyc(2);
    reset_b = 1'b1;
    cyc(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
